heater_sequencer: RTL and testbench
===================================

# heater_sequencer

Controller for an array of identical heater lanes, each an LFSR → SRL → BRAM → DSP → pipeline → checker delay chain with its own enable and checker clear. Ramps lanes on and off one at a time at a fixed interval, which bounds supply current steps. Holds every checker in clear until all enabled chains have flushed stale data. Collects per-lane sticky errors and a saturating error count for the status logic.

## Interface
- N_LANES, 16, number of heater lanes controlled (1..64)
- RAMP_CYCLES, 1024, cycles between successive lane enables/disables (≥2)
- SETTLE_CYCLES, 2048, flush time before checking starts; must exceed BRAM depth plus chain pipeline depth (≥2)
- CNT_W, 16, error counter width
- clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to ramp up; accepted only in IDLE
- stop  in  1  one-cycle request to ramp down; ignored in IDLE
- target  in  $clog2(N_LANES+1)  lane count to enable, sampled with accepted start
- err_clear  in  1  clears error_sticky and error_count
- lane_error  in  N_LANES  per-lane checker error outputs
- lane_en  out  N_LANES  per-lane enable (LFSR dv_in / clock-enable)
- lane_err_clear  out  N_LANES  per-lane checker reset
- state  out  3  current heater_state_t
- active_count  out  $clog2(N_LANES+1)  number of lanes enabled
- busy  out  1  high in every state except IDLE
- error_sticky  out  N_LANES  per-lane latched error
- error_any  out  1  OR of error_sticky
- error_count  out  CNT_W  saturating count of error cycles

## Operation
- Reset values: state=IDLE, lane_en=0, lane_err_clear=all 1, active_count=0, busy=0, error_sticky=0, error_any=0, error_count=0; all outputs registered.
- IDLE: lane_en=0, lane_err_clear all 1. start with target≠0 latches min(target, N_LANES) and enters RAMP_UP. start with target=0 is ignored.
- RAMP_UP: lane 0 is enabled on entry. Each next-higher lane is enabled every RAMP_CYCLES. Enabled lanes keep lane_err_clear=1. Once active_count equals the latched target, the next state is SETTLE.
- SETTLE: lasts exactly SETTLE_CYCLES. On exit, lane_err_clear drops for enabled lanes only and the state becomes RUN.
- RUN: for each enabled lane, lane_error=1 sets its error_sticky bit. error_count increments by 1 in every cycle with any enabled lane_error=1, and saturates at all-ones. lane_error from disabled lanes, or in any state other than RUN, is ignored.
- RAMP_DOWN: entered on stop from RAMP_UP, SETTLE or RUN. All lane_err_clear are reasserted immediately. The highest enabled lane is disabled on entry, then one more every RAMP_CYCLES. The cycle after active_count reaches 0, the state becomes IDLE.
- start outside IDLE is ignored. start and stop together in IDLE: start is taken. stop together with a RAMP_UP enable tick: stop wins and no lane is added.
- err_clear together with a new RUN error: the set wins (sticky bit=1, error_count=1). Other bits and the count are cleared.
- error_sticky and error_count persist through ramp-down and IDLE; only err_clear or reset clears them.
- reset_n low mid-operation: all lanes drop asynchronously to the reset values; there is no ramp-down.

## Timing
- Accepted start at edge t gives state=RAMP_UP and lane_en[0]=1 from cycle t+1.
- Lane k is enabled at t+1+k·RAMP_CYCLES.
- With latched target T: SETTLE at t+2+(T−1)·RAMP_CYCLES; RUN and lane_err_clear low at t+2+(T−1)·RAMP_CYCLES+SETTLE_CYCLES.
- lane_error sampled at edge e is reflected in error_sticky/error_count at cycle e+1. error_any follows at e+1 (combinational OR of registered bits, then registered; +1 cycle allowed: e+2).
- stop at edge u gives RAMP_DOWN, all lane_err_clear=1 and the top lane dropped at u+1. Further drops come every RAMP_CYCLES. With A active lanes, IDLE at u+2+(A−1)·RAMP_CYCLES.

## Structure
- heater_pkg holds:
  - heater_state_t enum (IDLE=0, RAMP_UP=1, SETTLE=2, RUN=3, RAMP_DOWN=4), 3 bits
  - function for lane-count width
- Sub-module heater_interval_timer:
  - loadable down-counter with load value, load strobe and expire pulse
  - shared by the ramp and settle phases
- The FSM, lane mask register and error logic live in heater_sequencer.

## Test plan
1. N_LANES=4, RAMP=8, SETTLE=16, start at t with target=3 → lane_en 0001@t+1, 0011@t+9, 0111@t+17; SETTLE@t+18; RUN with lane_err_clear=1000@t+34.
2. In RUN, pulse lane_error[1] for 2 cycles and lane_error[3] (disabled) → error_sticky=0010, error_count=2, error_any=1. err_clear alone → all zero.
3. stop in RUN with 3 lanes active at u → lane_err_clear=1111@u+1, lane_en 0011@u+1, 0001@u+9, 0000@u+17; IDLE@u+18; sticky bits retained.
4. stop during RAMP_UP after 2 lanes enabled → no third lane; ramp-down from 2. start during RAMP_DOWN is ignored.
5. target=0 → stays IDLE. target=7 with N_LANES=4 → ramps to 4. error_count preset near max saturates at 0xFFFF. err_clear coincident with an error → count=1.
6. reset_n low during SETTLE → lane_en=0, lane_err_clear=1111 without waiting for an edge. After release, a new start ramps normally.

Source files
------------

// File: rtl/heater_pkg.sv
// Shared types and helpers for the heater lane sequencer.
// Holds the sequencer state encoding and width helpers used for port
// and counter sizing in the sequencer and its interval timer.
package heater_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        SETTLE    = 3'd2,
        RUN       = 3'd3,
        RAMP_DOWN = 3'd4
    } heater_state_t;

    // Bits needed to hold a lane count from 0 up to n_lanes inclusive.
    function automatic int lane_cnt_w(input int n_lanes);
        return $clog2(n_lanes + 1);
    endfunction

    // Bits needed for a down-counter that must hold the larger of two loads.
    function automatic int timer_w(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/heater_interval_timer.sv
// Loadable down-counter shared by the ramp interval and the settle window.
// Ports: clk/reset_n; i_load + i_load_val restart the count; o_expire is
// high during the last cycle of the loaded interval (count == 1).
module heater_interval_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_expire
);

    logic [W-1:0] r_cnt;

    // Counts down to zero and parks there; a load always takes priority,
    // so a reload in the expiring cycle gives back-to-back intervals.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    // Loading N at edge t makes o_expire high in cycle t+N, so the action
    // it triggers lands exactly N cycles after the load.
    assign o_expire = (r_cnt == W'(1));

endmodule

// File: rtl/heater_sequencer.sv
// Heater lane sequencer: ramps lanes on/off one per RAMP_CYCLES, holds the
// checkers in clear through a SETTLE_CYCLES flush, then gathers errors.
// Ports: start/stop/target control the ramp; lane_en/lane_err_clear drive
// the lanes; state/active_count/busy and error_* report status. All outputs
// are registered.
module heater_sequencer
    import heater_pkg::*;
#(
    parameter int N_LANES       = 16,
    parameter int RAMP_CYCLES   = 1024,
    parameter int SETTLE_CYCLES = 2048,
    parameter int CNT_W         = 16
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              start,
    input  logic                              stop,
    input  logic [lane_cnt_w(N_LANES)-1:0]    target,
    input  logic                              err_clear,
    input  logic [N_LANES-1:0]                lane_error,
    output logic [N_LANES-1:0]                lane_en,
    output logic [N_LANES-1:0]                lane_err_clear,
    output heater_state_t                     state,
    output logic [lane_cnt_w(N_LANES)-1:0]    active_count,
    output logic                              busy,
    output logic [N_LANES-1:0]                error_sticky,
    output logic                              error_any,
    output logic [CNT_W-1:0]                  error_count
);

    localparam int                CW        = lane_cnt_w(N_LANES);
    localparam int                TW        = timer_w(RAMP_CYCLES, SETTLE_CYCLES);
    localparam logic [CW-1:0]     MAX_LANES = CW'(N_LANES);
    localparam logic [TW-1:0]     RAMP_LD   = TW'(RAMP_CYCLES);
    localparam logic [TW-1:0]     SETTLE_LD = TW'(SETTLE_CYCLES);
    localparam logic [N_LANES-1:0] LANE0    = N_LANES'(1);

    heater_state_t          r_state;
    logic [N_LANES-1:0]     r_lane_en;
    logic [N_LANES-1:0]     r_lane_err_clear;
    logic [CW-1:0]          r_active;
    logic [CW-1:0]          r_target;
    logic                   r_busy;
    logic [N_LANES-1:0]     r_error_sticky;
    logic                   r_error_any;
    logic [CNT_W-1:0]       r_error_count;

    logic                   w_start_ok;
    logic                   w_stop_ok;
    logic                   w_to_settle;
    logic                   w_add;
    logic                   w_to_run;
    logic                   w_to_idle;
    logic                   w_drop;
    logic                   w_expire;
    logic                   w_tmr_load;
    logic [TW-1:0]          w_tmr_val;
    logic [CW-1:0]          w_target_sat;
    logic [N_LANES-1:0]     w_err_hit;
    logic [N_LANES-1:0]     w_sticky_nxt;

    // Transition decode, shared by the FSM and the timer reload so the two
    // can never disagree about when an interval starts.
    always_comb begin
        w_start_ok   = (r_state == IDLE) && start && (target != '0);
        w_stop_ok    = stop && ((r_state == RAMP_UP) || (r_state == SETTLE) ||
                                (r_state == RUN));
        // stop beats a coincident ramp tick, so no lane is added
        w_to_settle  = (r_state == RAMP_UP) && !stop && (r_active == r_target);
        w_add        = (r_state == RAMP_UP) && !stop && (r_active != r_target) && w_expire;
        w_to_run     = (r_state == SETTLE) && !stop && w_expire;
        w_to_idle    = (r_state == RAMP_DOWN) && (r_active == '0);
        w_drop       = (r_state == RAMP_DOWN) && (r_active != '0) && w_expire;
        w_tmr_load   = w_start_ok || w_stop_ok || w_add || w_to_settle || w_drop;
        w_tmr_val    = w_to_settle ? SETTLE_LD : RAMP_LD;
        w_target_sat = (target > MAX_LANES) ? MAX_LANES : target;
    end

    heater_interval_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_expire   (w_expire)
    );

    // Lanes are always a contiguous block starting at lane 0, so adding
    // shifts a one in at the bottom and dropping shifts the top one out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= IDLE;
            r_lane_en        <= '0;
            r_lane_err_clear <= '1;
            r_active         <= '0;
            r_target         <= '0;
            r_busy           <= 1'b0;
        end else if (w_stop_ok) begin
            r_state          <= RAMP_DOWN;
            r_lane_err_clear <= '1;
            r_lane_en        <= r_lane_en >> 1;
            r_active         <= r_active - CW'(1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_state   <= RAMP_UP;
                        r_busy    <= 1'b1;
                        r_target  <= w_target_sat;
                        r_lane_en <= LANE0;
                        r_active  <= CW'(1);
                    end
                end
                RAMP_UP: begin
                    if (w_to_settle) begin
                        r_state <= SETTLE;
                    end else if (w_add) begin
                        r_lane_en <= (r_lane_en << 1) | LANE0;
                        r_active  <= r_active + CW'(1);
                    end
                end
                SETTLE: begin
                    if (w_to_run) begin
                        r_state          <= RUN;
                        // only enabled lanes leave clear; idle lanes stay held
                        r_lane_err_clear <= ~r_lane_en;
                    end
                end
                RUN: begin
                end
                RAMP_DOWN: begin
                    if (w_to_idle) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_drop) begin
                        r_lane_en <= r_lane_en >> 1;
                        r_active  <= r_active - CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Errors count only from enabled lanes while checking is live; a new
    // error in the same cycle as err_clear survives the clear.
    always_comb begin
        w_err_hit    = (r_state == RUN) ? (lane_error & r_lane_en) : '0;
        w_sticky_nxt = err_clear ? w_err_hit : (r_error_sticky | w_err_hit);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_error_sticky <= '0;
            r_error_any    <= 1'b0;
            r_error_count  <= '0;
        end else begin
            r_error_sticky <= w_sticky_nxt;
            r_error_any    <= |w_sticky_nxt;
            if (err_clear) begin
                r_error_count <= (|w_err_hit) ? CNT_W'(1) : '0;
            end else if ((|w_err_hit) && !(&r_error_count)) begin
                r_error_count <= r_error_count + CNT_W'(1);
            end
        end
    end

    assign lane_en        = r_lane_en;
    assign lane_err_clear = r_lane_err_clear;
    assign state          = r_state;
    assign active_count   = r_active;
    assign busy           = r_busy;
    assign error_sticky   = r_error_sticky;
    assign error_any      = r_error_any;
    assign error_count    = r_error_count;

endmodule

// File: tb/tb_heater_sequencer.sv
// Randomized and directed bench for heater_sequencer with a timestamp-based
// reference model: lane/phase changes are scheduled as absolute edge numbers
// from the documented timing rules and compared every cycle.
module tb_heater_sequencer;

    localparam int N    = 4;
    localparam int R    = 8;
    localparam int S    = 16;
    localparam int CMAX = 65535;

    localparam int M_IDLE = 0, M_UP = 1, M_SETTLE = 2, M_RUN = 3, M_DOWN = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start = 1'b0, stop = 1'b0, err_clear = 1'b0;
    logic [2:0] target = '0;
    logic [3:0] lane_error = '0;

    logic [3:0]  lane_en, lane_err_clear, error_sticky;
    logic [2:0]  state, active_count;
    logic        busy, error_any;
    logic [15:0] error_count;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model
    int         m_state, m_active, m_target, m_next, m_cnt, ecyc;
    logic [3:0] m_clr, m_sticky;

    always #5 clk = ~clk;

    heater_sequencer #(
        .N_LANES       (N),
        .RAMP_CYCLES   (R),
        .SETTLE_CYCLES (S),
        .CNT_W         (16)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .stop           (stop),
        .target         (target),
        .err_clear      (err_clear),
        .lane_error     (lane_error),
        .lane_en        (lane_en),
        .lane_err_clear (lane_err_clear),
        .state          (state),
        .active_count   (active_count),
        .busy           (busy),
        .error_sticky   (error_sticky),
        .error_any      (error_any),
        .error_count    (error_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [3:0] lanes(input int n);
        int v;
        v = (1 << n) - 1;
        return v[3:0];
    endfunction

    task automatic model_reset();
        m_state  = M_IDLE;
        m_active = 0;
        m_target = 0;
        m_next   = 0;
        m_clr    = 4'hF;
        m_sticky = 4'h0;
        m_cnt    = 0;
    endtask

    task automatic enter_down();
        m_state  = M_DOWN;
        m_active = m_active - 1;
        m_clr    = 4'hF;
        m_next   = ecyc + R;
    endtask

    // Advance the model by one rising edge using the inputs that edge sampled.
    task automatic model_step();
        logic [3:0] hit;
        if (!reset_n) begin
            model_reset();
            return;
        end
        ecyc++;
        hit = (m_state == M_RUN) ? (lane_error & lanes(m_active)) : 4'h0;
        if (err_clear) begin
            m_sticky = hit;
            m_cnt    = (hit != 0) ? 1 : 0;
        end else begin
            m_sticky = m_sticky | hit;
            if (hit != 0 && m_cnt < CMAX) m_cnt++;
        end
        case (m_state)
            M_IDLE: if (start && target != 0) begin
                m_state  = M_UP;
                m_target = (int'(target) > N) ? N : int'(target);
                m_active = 1;
                m_next   = ecyc + R;
            end
            M_UP: begin
                if (stop) enter_down();
                else if (m_active == m_target) begin
                    m_state = M_SETTLE;
                    m_next  = ecyc + S;
                end else if (ecyc == m_next) begin
                    m_active++;
                    m_next = ecyc + R;
                end
            end
            M_SETTLE: begin
                if (stop) enter_down();
                else if (ecyc == m_next) begin
                    m_state = M_RUN;
                    m_clr   = ~lanes(m_active);
                end
            end
            M_RUN: if (stop) enter_down();
            default: begin
                if (m_active == 0) m_state = M_IDLE;
                else if (ecyc == m_next) begin
                    m_active--;
                    m_next = ecyc + R;
                end
            end
        endcase
    endtask

    task automatic check_all();
        check("state",        state,          m_state);
        check("lane_en",      lane_en,        lanes(m_active));
        check("lane_err_clr", lane_err_clear, m_clr);
        check("active_count", active_count,   m_active);
        check("busy",         busy,           (m_state != M_IDLE));
        check("error_sticky", error_sticky,   m_sticky);
        check("error_any",    error_any,      (m_sticky != 0));
        check("error_count",  error_count,    m_cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic pulse_start(input logic [2:0] t);
        start  = 1'b1;
        target = t;
        tick();
        start  = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        ecyc = 0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        model_reset();
        #1 check_all();
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // ramp to 3 lanes, settle, run
        pulse_start(3'd3);
        repeat (40) tick();

        // enabled lane 1 errors twice; disabled lane 3 is ignored
        lane_error = 4'b1010;
        tick();
        tick();
        lane_error = 4'b0000;
        tick();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        tick();

        repeat (20) begin
            lane_error = 4'($urandom);
            err_clear  = (($urandom % 6) == 0);
            tick();
        end
        lane_error = 4'b0010;
        err_clear  = 1'b0;
        tick();
        lane_error = 4'b0000;

        // ramp down from 3; sticky bits retained
        pulse_stop();
        repeat (25) tick();

        // stop mid-ramp-up after 2 lanes; start in ramp-down ignored
        pulse_start(3'd7);
        repeat (10) tick();
        pulse_stop();
        pulse_start(3'd2);
        repeat (15) tick();

        // target 0 ignored; target 7 clamps to 4
        pulse_start(3'd0);
        repeat (3) tick();
        pulse_start(3'd7);
        repeat (50) tick();
        pulse_stop();
        repeat (35) tick();

        // saturation, then err_clear together with an error
        pulse_start(3'd1);
        repeat (25) tick();
        lane_error = 4'b0001;
        repeat (65540) tick();
        err_clear = 1'b1;
        tick();
        err_clear  = 1'b0;
        lane_error = 4'b0000;
        tick();
        pulse_stop();
        repeat (12) tick();

        // randomized control and error traffic
        repeat (3000) begin
            start      = (($urandom % 40) == 0);
            stop       = (($urandom % 120) == 0);
            target     = 3'($urandom);
            lane_error = (($urandom % 4) == 0) ? 4'($urandom) : 4'h0;
            err_clear  = (($urandom % 50) == 0);
            tick();
        end
        start = 1'b0;
        stop = 1'b0;
        lane_error = 4'h0;
        err_clear = 1'b0;
        pulse_stop();
        repeat (40) tick();

        // asynchronous reset during SETTLE
        pulse_start(3'd2);
        repeat (12) tick();
        check("settle_before_reset", state, M_SETTLE);
        #2 reset_n = 1'b0;
        model_reset();
        #1 check_all();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        pulse_start(3'd2);
        repeat (40) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
